// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - control/BRAM-facing signal bundle of the instruction fetch unit
// master drives strobes and BRAM read data; slave is the fetch unit itself.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              IR_enable;
  logic              PC_enable;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              fetch_busy;
  logic              fetch_done;
  logic              fetch_overrun;

  modport master (
    output IR_enable, PC_enable, pc_load, pc_load_val, mem_rdata,
    input  mem_addr, mem_rd_en, pc, ir, fetch_busy, fetch_done, fetch_overrun
  );

  modport slave (
    input  IR_enable, PC_enable, pc_load, pc_load_val, mem_rdata,
    output mem_addr, mem_rd_en, pc, ir, fetch_busy, fetch_done, fetch_overrun
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register, BRAM instruction read sequencer and instruction register
// Optional FETCH_OVERRUN_EN: sticky flag for fetch requests dropped while busy.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                BRAM_LAT = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t            state_q, state_n;
  logic [1:0]        cnt_q, cnt_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] ir_q, ir_n;
  logic              rd_en_q, rd_en_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [ADDR_W-1:0] pc_q;
  logic              ir_prev_q, pc_prev_q;
  logic              ir_rise, pc_rise;

  // Control strobes are levels; only the low-to-high transition means anything.
  assign ir_rise = bus.IR_enable & ~ir_prev_q;
  assign pc_rise = bus.PC_enable & ~pc_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_prev_q <= 1'b0;
      pc_prev_q <= 1'b0;
    end else begin
      ir_prev_q <= bus.IR_enable;
      pc_prev_q <= bus.PC_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      ir_q    <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      ir_q    <= ir_n;
      rd_en_q <= rd_en_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    ir_n    = ir_q;
    rd_en_n = 1'b0;
    busy_n  = busy_q;
    done_n  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Address is taken from the pre-update pc, so a same-edge branch does not redirect this fetch.
        if (ir_rise) begin
          addr_n  = pc_q;
          rd_en_n = 1'b1;
          busy_n  = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        cnt_n   = 2'(BRAM_LAT - 1);
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_n = S_CAPTURE;
        end else begin
          cnt_n = cnt_q - 2'd1;
        end
      end
      S_CAPTURE: begin
        ir_n    = bus.mem_rdata;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // PC runs independently of the fetch sequencer; a branch load beats an advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (bus.pc_load) begin
      pc_q <= bus.pc_load_val;
    end else if (pc_rise) begin
      pc_q <= pc_q + 1'b1;
    end
  end

`ifdef FETCH_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (ir_rise && busy_q) begin
      overrun_q <= 1'b1;
    end
  end

  assign bus.fetch_overrun = overrun_q;
`else
  assign bus.fetch_overrun = 1'b0;
`endif

  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.pc         = pc_q;
  assign bus.ir         = ir_q;
  assign bus.fetch_busy = busy_q;
  assign bus.fetch_done = done_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench: BRAM_LAT=1 and BRAM_LAT=3 units driven in lockstep
// Reference model tracks fetches as transactions scheduled by cycle number.
module tb_instr_fetch_unit;
  localparam int AW = 16;
  localparam int DW = 16;
`ifdef FETCH_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ir_en, pc_en, pc_ld;
  logic [AW-1:0] pc_ld_val;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  assign b1.IR_enable   = ir_en;
  assign b1.PC_enable   = pc_en;
  assign b1.pc_load     = pc_ld;
  assign b1.pc_load_val = pc_ld_val;
  assign b3.IR_enable   = ir_en;
  assign b3.PC_enable   = pc_en;
  assign b3.pc_load     = pc_ld;
  assign b3.pc_load_val = pc_ld_val;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .BRAM_LAT(1), .RESET_PC(16'h0000)) u_dut_lat1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .BRAM_LAT(3), .RESET_PC(16'h0000)) u_dut_lat3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] r1;
  logic [DW-1:0] r3 [0:2];

  always @(posedge clk) begin
    if (b1.mem_rd_en) r1 <= mem[b1.mem_addr];
  end

  always @(posedge clk) begin
    if (b3.mem_rd_en) r3[0] <= mem[b3.mem_addr];
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end

  assign b1.mem_rdata = r1;
  assign b3.mem_rdata = r3[2];

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] m_pc [2];
  logic [DW-1:0] m_ir [2];
  logic [AW-1:0] m_addr [2];
  bit            m_busy [2];
  bit            m_rd [2];
  bit            m_done [2];
  bit            m_ovr [2];
  int            m_start [2];
  bit            m_prev_ir, m_prev_pc;
  int            cyc;

  logic [AW-1:0] a_pc [2];
  logic [DW-1:0] a_ir [2];
  logic [AW-1:0] a_addr [2];
  logic          a_rd [2];
  logic          a_busy [2];
  logic          a_done [2];
  logic          a_ovr [2];

  task automatic model_step();
    bit ir_rise, pc_rise, was_busy;
    int lat;
    ir_rise = ir_en && !m_prev_ir;
    pc_rise = pc_en && !m_prev_pc;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      if (reset) begin
        m_pc[d] = 16'h0000; m_ir[d] = '0; m_addr[d] = '0;
        m_busy[d] = 0; m_rd[d] = 0; m_done[d] = 0; m_ovr[d] = 0;
      end else begin
        m_rd[d] = 0;
        m_done[d] = 0;
        was_busy = m_busy[d];
        if (m_busy[d] && cyc == m_start[d] + 2 + lat) begin
          m_ir[d] = mem[m_addr[d]];
          m_done[d] = 1;
          m_busy[d] = 0;
        end
        if (ir_rise && was_busy && OVR_EN) m_ovr[d] = 1;
        if (ir_rise && !was_busy) begin
          m_addr[d] = m_pc[d];
          m_start[d] = cyc;
          m_busy[d] = 1;
          m_rd[d] = 1;
        end
        if (pc_ld) m_pc[d] = pc_ld_val;
        else if (pc_rise) m_pc[d] = m_pc[d] + 16'd1;
      end
    end
    if (reset) begin
      m_prev_ir = 0;
      m_prev_pc = 0;
    end else begin
      m_prev_ir = ir_en;
      m_prev_pc = pc_en;
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    a_pc[0] = b1.pc;   a_ir[0] = b1.ir;   a_addr[0] = b1.mem_addr;   a_rd[0] = b1.mem_rd_en;
    a_busy[0] = b1.fetch_busy; a_done[0] = b1.fetch_done; a_ovr[0] = b1.fetch_overrun;
    a_pc[1] = b3.pc;   a_ir[1] = b3.ir;   a_addr[1] = b3.mem_addr;   a_rd[1] = b3.mem_rd_en;
    a_busy[1] = b3.fetch_busy; a_done[1] = b3.fetch_done; a_ovr[1] = b3.fetch_overrun;
  endtask

  task automatic test_reset();
    reset = 1; ir_en = 1; pc_en = 0; pc_ld = 0; pc_ld_val = '0;
    cycle(); cycle();
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({a_pc[d], a_ir[d], a_addr[d], a_rd[d], a_busy[d], a_done[d], a_ovr[d]} !== 52'd0)
        $display("FAIL reset_state[%0d]: got pc=%h ir=%h addr=%h rd=%b busy=%b done=%b ovr=%b, expected all zero",
                 d, a_pc[d], a_ir[d], a_addr[d], a_rd[d], a_busy[d], a_done[d], a_ovr[d]);
      else n_pass++;
    end
    reset = 0;
    cycle();
    n_checks++;
    if ({a_rd[0], a_addr[0], a_busy[0]} !== {1'b1, 16'h0000, 1'b1})
      $display("FAIL first_req: got rd=%b addr=%h busy=%b, expected rd=1 addr=0000 busy=1", a_rd[0], a_addr[0], a_busy[0]);
    else n_pass++;
    cycle();
    n_checks++;
    if (a_rd[0] !== 1'b0) $display("FAIL rd_one_cycle: got %b expected 0", a_rd[0]);
    else n_pass++;
    cycle();
    n_checks++;
    if (a_done[0] !== 1'b0) $display("FAIL done_early_lat1: got %b expected 0", a_done[0]);
    else n_pass++;
    cycle();
    n_checks++;
    if ({a_done[0], a_ir[0], a_busy[0]} !== {1'b1, 16'hA5A5, 1'b0})
      $display("FAIL capture_lat1: got done=%b ir=%h busy=%b, expected done=1 ir=a5a5 busy=0", a_done[0], a_ir[0], a_busy[0]);
    else n_pass++;
    cycle();
    n_checks++;
    if ({a_done[0], a_done[1]} !== 2'b00) $display("FAIL done_pulse: got %b%b expected 00", a_done[0], a_done[1]);
    else n_pass++;
    cycle();
    n_checks++;
    if ({a_done[1], a_ir[1]} !== {1'b1, 16'hA5A5})
      $display("FAIL capture_lat3: got done=%b ir=%h, expected done=1 ir=a5a5", a_done[1], a_ir[1]);
    else n_pass++;
    ir_en = 0;
    cycle();
  endtask

  task automatic test_pc_advance();
    reset = 1; cycle(); reset = 0;
    pc_en = 1;
    repeat (5) cycle();
    pc_en = 0;
    n_checks++;
    if (a_pc[0] !== 16'd1) $display("FAIL pc_level_hold: got %h expected 0001", a_pc[0]);
    else n_pass++;
    reset = 1; cycle(); reset = 0;
    repeat (2) begin
      pc_en = 1; cycle();
      pc_en = 0; cycle();
    end
    n_checks++;
    if ({a_pc[0], a_pc[1]} !== {16'd2, 16'd2}) $display("FAIL pc_two_pulses: got %h/%h expected 0002/0002", a_pc[0], a_pc[1]);
    else n_pass++;
  endtask

  task automatic test_pc_wrap();
    pc_ld = 1; pc_ld_val = 16'hFFFF; cycle(); pc_ld = 0;
    n_checks++;
    if (a_pc[1] !== 16'hFFFF) $display("FAIL pc_load: got %h expected ffff", a_pc[1]);
    else n_pass++;
    pc_en = 1; cycle();
    n_checks++;
    if (a_pc[1] !== 16'h0000) $display("FAIL pc_wrap: got %h expected 0000", a_pc[1]);
    else n_pass++;
    pc_en = 0; cycle();
    pc_ld = 1; pc_ld_val = 16'h0040; pc_en = 1; cycle();
    pc_ld = 0; pc_en = 0;
    n_checks++;
    if (a_pc[1] !== 16'h0040) $display("FAIL load_priority: got %h expected 0040", a_pc[1]);
    else n_pass++;
    cycle();
  endtask

  task automatic test_inflight_load();
    reset = 1; cycle(); reset = 0;
    pc_ld = 1; pc_ld_val = 16'h0005; cycle(); pc_ld = 0;
    ir_en = 1; cycle();
    cycle();
    pc_ld = 1; pc_ld_val = 16'h0010; cycle(); pc_ld = 0;
    n_checks++;
    if ({a_pc[1], a_addr[1]} !== {16'h0010, 16'h0005})
      $display("FAIL inflight_addr: got pc=%h addr=%h expected pc=0010 addr=0005", a_pc[1], a_addr[1]);
    else n_pass++;
    cycle();
    n_checks++;
    if ({a_done[0], a_ir[0], a_done[1]} !== {1'b1, mem[5], 1'b0})
      $display("FAIL inflight_k3: got done1=%b ir1=%h done3=%b expected 1 %h 0", a_done[0], a_ir[0], a_done[1], mem[5]);
    else n_pass++;
    cycle(); cycle();
    n_checks++;
    if ({a_done[1], a_ir[1], a_addr[1], a_pc[1]} !== {1'b1, mem[5], 16'h0005, 16'h0010})
      $display("FAIL inflight_k5: got done=%b ir=%h addr=%h pc=%h expected 1 %h 0005 0010",
               a_done[1], a_ir[1], a_addr[1], a_pc[1], mem[5]);
    else n_pass++;
    ir_en = 0; cycle();
  endtask

  task automatic test_overrun();
    int rd_cnt = 0;
    reset = 1; ir_en = 0; cycle(); reset = 0; cycle();
    ir_en = 1; cycle(); rd_cnt += int'(a_rd[1]);
    ir_en = 0; cycle(); rd_cnt += int'(a_rd[1]);
    ir_en = 1; cycle(); rd_cnt += int'(a_rd[1]);
    repeat (6) begin cycle(); rd_cnt += int'(a_rd[1]); end
    n_checks++;
    if (rd_cnt !== 1) $display("FAIL dropped_req: got %0d read strobes expected 1", rd_cnt);
    else n_pass++;
    n_checks++;
    if ({a_ovr[0], a_ovr[1]} !== {OVR_EN, OVR_EN})
      $display("FAIL overrun_flag: got %b%b expected %b%b", a_ovr[0], a_ovr[1], OVR_EN, OVR_EN);
    else n_pass++;
    n_checks++;
    if ({a_ir[1], a_pc[1]} !== {16'hA5A5, 16'h0000})
      $display("FAIL overrun_ir_pc: got ir=%h pc=%h expected a5a5 0000", a_ir[1], a_pc[1]);
    else n_pass++;
    ir_en = 0; reset = 1; cycle(); reset = 0;
    n_checks++;
    if ({a_ovr[0], a_ovr[1]} !== 2'b00) $display("FAIL overrun_clear: got %b%b expected 00", a_ovr[0], a_ovr[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    bit done_seen = 0;
    pc_ld = 1; pc_ld_val = 16'h0007; cycle(); pc_ld = 0;
    ir_en = 1; cycle();
    cycle(); cycle();
    reset = 1; ir_en = 0; cycle();
    n_checks++;
    if ({a_done[0], a_done[1], a_ir[1], a_pc[1], a_rd[1], a_busy[1]} !== 36'd0)
      $display("FAIL reset_abort: got done=%b%b ir=%h pc=%h rd=%b busy=%b expected all zero",
               a_done[0], a_done[1], a_ir[1], a_pc[1], a_rd[1], a_busy[1]);
    else n_pass++;
    reset = 0;
    repeat (6) begin cycle(); done_seen |= a_done[0] | a_done[1]; end
    n_checks++;
    if (done_seen !== 1'b0) $display("FAIL abort_no_done: got done seen=%b expected 0", done_seen);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      ir_en     = $urandom_range(0, 1) == 1;
      pc_en     = $urandom_range(0, 1) == 1;
      pc_ld     = ($urandom_range(0, 9) == 0);
      pc_ld_val = 16'($urandom);
      cycle();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if ({a_pc[d], a_ir[d], a_addr[d], a_rd[d], a_busy[d], a_done[d], a_ovr[d]} !==
            {m_pc[d], m_ir[d], m_addr[d], m_rd[d], m_busy[d], m_done[d], m_ovr[d]})
          $display("FAIL random[%0d] cyc %0d: got pc=%h ir=%h addr=%h rd=%b busy=%b done=%b ovr=%b expected pc=%h ir=%h addr=%h rd=%b busy=%b done=%b ovr=%b",
                   d, cyc, a_pc[d], a_ir[d], a_addr[d], a_rd[d], a_busy[d], a_done[d], a_ovr[d],
                   m_pc[d], m_ir[d], m_addr[d], m_rd[d], m_busy[d], m_done[d], m_ovr[d]);
        else n_pass++;
      end
    end
    reset = 0; ir_en = 0; pc_en = 0; pc_ld = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA5A5;
    reset = 1; ir_en = 0; pc_en = 0; pc_ld = 0; pc_ld_val = '0;
    cyc = 0; m_prev_ir = 0; m_prev_pc = 0;
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = '0; m_ir[d] = '0; m_addr[d] = '0; m_start[d] = 0;
      m_busy[d] = 0; m_rd[d] = 0; m_done[d] = 0; m_ovr[d] = 0;
    end
    test_reset();
    test_pc_advance();
    test_pc_wrap();
    test_inflight_load();
    test_overrun();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
